// File: rtl/wordcell_pkg.sv
// Shared sizes and the controller state encoding for the wordcell array controller.
package wordcell_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int NUM_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/addr_decoder_3to8.sv
// Word index to one-hot cell select; all zeros when disabled.
module addr_decoder_3to8
    import wordcell_pkg::*;
(
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 en,
    output logic [NUM_WORDS-1:0] sel
);

    always_comb begin
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/wordcell_ctrl.sv
// Sequences one host access into SETUP/STROBE/HOLD phases on a latch-based wordcell array.
module wordcell_ctrl
    import wordcell_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 ready,
    output logic                 rvalid,
    output logic [DATA_W-1:0]    rdata,
    output logic                 cell_op,
    output logic [NUM_WORDS-1:0] cell_sel,
    output logic [DATA_W-1:0]    cell_in_bus,
    input  logic [DATA_W-1:0]    cell_out_bus
);

    ctrl_state_t          state, state_n;
    logic                 accept;
    logic [ADDR_W-1:0]    addr_q;
    logic [NUM_WORDS-1:0] sel_d;

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_n = SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP:   state_n = STROBE;
            STROBE:  state_n = HOLD;
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Select is decoded from the next state so the strobe comes straight out of a flop.
    addr_decoder_3to8 u_dec (
        .addr (addr_q),
        .en   (state_n == STROBE),
        .sel  (sel_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: reset is synchronous; a req seen in a reset cycle is dropped because this branch wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready       <= 1'b1;
            rvalid      <= 1'b0;
            rdata       <= '0;
            cell_op     <= 1'b0;
            cell_sel    <= '0;
            cell_in_bus <= '0;
            addr_q      <= '0;
        end else begin
            state    <= state_n;
            ready    <= (state_n == IDLE);
            rvalid   <= (state_n == HOLD) && !cell_op;
            cell_sel <= sel_d;
            // op and bus only move on accept, i.e. while every cell is deselected.
            if (accept) begin
                addr_q      <= addr;
                cell_op     <= we;
                cell_in_bus <= we ? wdata : '0;
            end
            if (state == STROBE && !cell_op) begin
                rdata <= cell_out_bus;
            end
        end
    end

endmodule

// File: tb/tb_wordcell_ctrl.sv
// Directed bench for wordcell_ctrl with eight behavioural wordcells on the shared buses.
module tb_wordcell_ctrl;
    import wordcell_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 req = 1'b0;
    logic                 we = 1'b0;
    logic [ADDR_W-1:0]    addr = '0;
    logic [DATA_W-1:0]    wdata = '0;
    logic                 ready, rvalid, cell_op;
    logic [DATA_W-1:0]    rdata, cell_in_bus, cell_out_bus;
    logic [NUM_WORDS-1:0] cell_sel;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    wordcell_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ready        (ready),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .cell_op      (cell_op),
        .cell_sel     (cell_sel),
        .cell_in_bus  (cell_in_bus),
        .cell_out_bus (cell_out_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wordcells: write while selected in write mode; deselected cells drive zero.
    logic [DATA_W-1:0] cell_mem [NUM_WORDS];
    initial for (int i = 0; i < NUM_WORDS; i++) cell_mem[i] = 8'h10 + 8'(i);
    always @(posedge clk) begin
        for (int i = 0; i < NUM_WORDS; i++)
            if (cell_sel[i] && cell_op) cell_mem[i] <= cell_in_bus;
    end
    always_comb begin
        cell_out_bus = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            if (cell_sel[i] && !cell_op) cell_out_bus = cell_out_bus | cell_mem[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor: at most one select bit, and op/bus frozen around any select.
    logic                 prev_op = 1'b0;
    logic [DATA_W-1:0]    prev_in = '0;
    logic [NUM_WORDS-1:0] prev_sel = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (cell_sel != '0) check("mon_onehot", 32'($countones(cell_sel)), 32'd1);
            if (cell_sel != '0 || prev_sel != '0) begin
                check("mon_op_stable", 32'(cell_op), 32'(prev_op));
                check("mon_bus_stable", 32'(cell_in_bus), 32'(prev_in));
            end
        end
        prev_op  = cell_op;
        prev_in  = cell_in_bus;
        prev_sel = cell_sel;
    end

    // One complete access starting at a negedge in IDLE; ends at the negedge of the next IDLE.
    task automatic access(input logic w, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input string name);
        int n = 0;
        logic [7:0] onehot;
        onehot = 8'd1 << a;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_wait"}, 32'(ready), 32'd1);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        check({name, "_setup_sel"}, 32'(cell_sel), 32'h00);
        check({name, "_setup_op"}, 32'(cell_op), 32'(w));
        check({name, "_setup_bus"}, 32'(cell_in_bus), w ? 32'(d) : 32'h00);
        check({name, "_setup_ready"}, 32'(ready), 32'd0);
        @(negedge clk);
        check({name, "_strobe_sel"}, 32'(cell_sel), 32'(onehot));
        check({name, "_strobe_rvalid"}, 32'(rvalid), 32'd0);
        @(negedge clk);
        check({name, "_hold_sel"}, 32'(cell_sel), 32'h00);
        check({name, "_hold_rvalid"}, 32'(rvalid), 32'(!w));
        check({name, "_hold_rdata"}, 32'(rdata), 32'(exp_rd));
        @(negedge clk);
        check({name, "_idle_ready"}, 32'(ready), 32'd1);
        check({name, "_idle_rvalid"}, 32'(rvalid), 32'd0);
    endtask

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int sel_seen;
        int rv_seen;
        int acc_cyc [3];
        int n_acc;

        vecs[0] = '{1'b1, 3'd3, 8'h55, 8'h00};
        vecs[1] = '{1'b0, 3'd3, 8'h00, 8'h55};
        vecs[2] = '{1'b0, 3'd2, 8'h00, 8'h12};
        vecs[3] = '{1'b0, 3'd4, 8'h00, 8'h14};
        vecs[4] = '{1'b1, 3'd0, 8'hCC, 8'h14};
        vecs[5] = '{1'b1, 3'd7, 8'h33, 8'h14};
        vecs[6] = '{1'b0, 3'd0, 8'h00, 8'hCC};
        vecs[7] = '{1'b0, 3'd7, 8'h00, 8'h33};

        // Reset held for two edges.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_sel", 32'(cell_sel), 32'h00);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_op", 32'(cell_op), 32'd0);
        check("rst_bus", 32'(cell_in_bus), 32'h00);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end
        check("untouched_word1", 32'(cell_mem[1]), 32'h11);

        // Busy ignore: a write to word 5 arrives during SETUP of a write to word 6.
        req = 1'b1; we = 1'b1; addr = 3'd6; wdata = 8'h66;
        @(negedge clk);
        addr = 3'd5; wdata = 8'hFF;
        check("busy_ready", 32'(ready), 32'd0);
        @(negedge clk);
        req = 1'b0;
        check("busy_strobe_sel", 32'(cell_sel), 32'h40);
        @(negedge clk);
        @(negedge clk);
        check("busy_idle_ready", 32'(ready), 32'd1);
        access(1'b0, 3'd5, 8'h00, 8'h15, "busy_rd5");
        access(1'b0, 3'd6, 8'h00, 8'h66, "busy_rd6");

        // Reset during SETUP of a read: the access must vanish.
        req = 1'b1; we = 1'b0; addr = 3'd3;
        @(negedge clk);
        req = 1'b0;
        check("abort_in_setup", 32'(cell_sel), 32'h00);
        rst = 1'b1;
        req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        sel_seen = 0;
        rv_seen = 0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_rdata", 32'(rdata), 32'h00);
        for (int i = 0; i < 6; i++) begin
            if (cell_sel != '0) sel_seen++;
            if (rvalid) rv_seen++;
            @(negedge clk);
        end
        check("abort_no_sel", 32'(sel_seen), 32'd0);
        check("abort_no_rvalid", 32'(rv_seen), 32'd0);
        check("abort_idle", 32'(ready), 32'd1);

        // Back-to-back: req held for three reads of word 7.
        n_acc = 0;
        rv_seen = 0;
        req = 1'b1; we = 1'b0; addr = 3'd7;
        for (int i = 0; i < 40 && n_acc < 3; i++) begin
            if (ready && req) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            if (rvalid) rv_seen++;
            if (n_acc == 3) req = 1'b0;
        end
        check("b2b_accepts", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
            check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rvalid) rv_seen++;
        end
        check("b2b_rvalids", 32'(rv_seen), 32'd3);
        check("b2b_rdata", 32'(rdata), 32'h33);
        check("b2b_ready", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
